// File: rtl/fifo_event_capture.sv
// fifo_event_capture: spike-event FIFO feeding a capture FSM that presents (x,y) coordinates to the conv core
// Optional CAPTURE_BOUNDS_CHECK_EN: drop out-of-image events in LATCH and pulse dropped_event.
module fifo_event_capture #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    write_en,
  input  logic [DATA_WIDTH-1:0]   write_data,
  output logic                    full,
  output logic                    empty,
  output logic [ADDR_WIDTH:0]     fifo_count,
  output logic                    fifo_read_en,
  input  logic                    enable,
  output logic                    active,
  input  logic                    event_ready,
  input  logic                    event_ack,
  output logic                    event_valid,
`ifdef CAPTURE_BOUNDS_CHECK_EN
  output logic                    dropped_event,
`endif
  output logic [DATA_WIDTH/2-1:0] event_x,
  output logic [DATA_WIDTH/2-1:0] event_y
);
  localparam int COORD_BITS = DATA_WIDTH / 2;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  typedef enum logic [1:0] {IDLE, FETCH, LATCH, VALID} state_t;
  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_read_data;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  w_push;
  logic                  w_keep;
  assign w_push       = write_en && !full;
  assign full         = r_count[ADDR_WIDTH];
  assign empty        = r_count == '0;
  assign fifo_count   = r_count;
  assign active       = r_state != IDLE;
  assign fifo_read_en = (r_state == IDLE) && enable && event_ready && !empty;
`ifdef CAPTURE_BOUNDS_CHECK_EN
  assign w_keep = (32'(r_read_data[DATA_WIDTH-1:COORD_BITS]) < IMG_WIDTH) &&
                  (32'(r_read_data[COORD_BITS-1:0]) < IMG_HEIGHT);
`else
  assign w_keep = 1'b1;
`endif
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= write_data;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_read_data <= '0;
      r_state     <= IDLE;
      event_valid <= 1'b0;
      event_x     <= '0;
      event_y     <= '0;
`ifdef CAPTURE_BOUNDS_CHECK_EN
      dropped_event <= 1'b0;
`endif
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (fifo_read_en) begin
        r_rd_ptr    <= r_rd_ptr + 1'b1;
        r_read_data <= r_mem[r_rd_ptr];
      end
      if (w_push && !fifo_read_en) r_count <= r_count + 1'b1;
      else if (fifo_read_en && !w_push) r_count <= r_count - 1'b1;
`ifdef CAPTURE_BOUNDS_CHECK_EN
      dropped_event <= (r_state == LATCH) && !w_keep;
`endif
      case (r_state)
        IDLE: if (fifo_read_en) r_state <= FETCH;
        FETCH: r_state <= LATCH;
        LATCH: begin
          r_state     <= w_keep ? VALID : IDLE;
          event_valid <= w_keep;
          if (w_keep) begin
            event_x <= r_read_data[DATA_WIDTH-1:COORD_BITS];
            event_y <= r_read_data[COORD_BITS-1:0];
          end
        end
        VALID: if (event_ack) begin
          r_state     <= IDLE;
          event_valid <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_event_capture.sv
// tb_fifo_event_capture: directed + random check of fifo_event_capture against a queue-based event model
module tb_fifo_event_capture;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       write_en = 1'b0;
  logic [15:0] write_data = '0;
  logic       full, empty, fifo_read_en, active, event_valid;
  logic [3:0] fifo_count;
  logic       enable = 1'b0;
  logic       event_ready = 1'b0;
  logic       event_ack = 1'b0;
  logic [7:0] event_x, event_y;
`ifdef CAPTURE_BOUNDS_CHECK_EN
  logic       dropped_event;
`endif
  int total = 0;
  int bad = 0;
  int n_pops = 0;
  int n_drops = 0;
  always #5 clk = ~clk;

  fifo_event_capture dut (
    .clk(clk), .rst_n(rst_n), .write_en(write_en), .write_data(write_data),
    .full(full), .empty(empty), .fifo_count(fifo_count), .fifo_read_en(fifo_read_en),
    .enable(enable), .active(active), .event_ready(event_ready), .event_ack(event_ack),
    .event_valid(event_valid),
`ifdef CAPTURE_BOUNDS_CHECK_EN
    .dropped_event(dropped_event),
`endif
    .event_x(event_x), .event_y(event_y)
  );

  // model: queue of pending events, plus the one event in flight and cycles since its pop
  logic [15:0] q[$];
  logic [15:0] m_evt;
  bit   m_busy, m_valid, m_drop;
  int   m_age;
  logic [7:0] m_x, m_y;

  function automatic bit in_range(input logic [15:0] e);
`ifdef CAPTURE_BOUNDS_CHECK_EN
    return (e[15:8] < 8'd32) && (e[7:0] < 8'd32);
`else
    return 1'b1;
`endif
  endfunction

  function automatic bit exp_rd();
    return !m_busy && enable && event_ready && q.size() != 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit pop, push;
    pop = exp_rd();
    push = write_en && q.size() < 8;
    m_drop = 1'b0;
    if (!rst_n) begin
      q.delete();
      m_busy = 1'b0;
      m_valid = 1'b0;
      m_age = 0;
      m_x = '0;
      m_y = '0;
    end else begin
      if (m_valid) begin
        if (event_ack) begin
          m_valid = 1'b0;
          m_busy = 1'b0;
        end
      end else if (m_busy) begin
        m_age++;
        if (m_age == 2) begin
          if (in_range(m_evt)) begin
            m_valid = 1'b1;
            m_x = m_evt[15:8];
            m_y = m_evt[7:0];
          end else begin
            m_busy = 1'b0;
            m_drop = 1'b1;
          end
        end
      end
      if (pop) begin
        m_evt = q.pop_front();
        m_busy = 1'b1;
        m_age = 0;
      end
      if (push) q.push_back(write_data);
    end
  end

  always @(negedge clk) begin
    chk("full", 32'(full), 32'(q.size() == 8));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("count", 32'(fifo_count), 32'(q.size()));
    chk("rd_en", 32'(fifo_read_en), 32'(exp_rd()));
    chk("active", 32'(active), 32'(m_busy));
    chk("valid", 32'(event_valid), 32'(m_valid));
    chk("x", 32'(event_x), 32'(m_x));
    chk("y", 32'(event_y), 32'(m_y));
`ifdef CAPTURE_BOUNDS_CHECK_EN
    chk("drop", 32'(dropped_event), 32'(m_drop));
    if (dropped_event === 1'b1) n_drops++;
`endif
    if (fifo_read_en === 1'b1) n_pops++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (event_valid !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    chk("wait_valid", 32'(event_valid), 32'd1);
  endtask

  task automatic write_ev(input logic [15:0] d);
    write_en = 1'b1;
    write_data = d;
    tick();
    write_en = 1'b0;
  endtask

  initial begin
    int p0;
    tick();
    tick();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_valid", 32'(event_valid), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    rst_n = 1'b1;
    enable = 1'b1;
    write_ev(16'h0A14);
    repeat (4) tick();
    chk("gate_active", 32'(active), 32'd0);
    chk("gate_pops", 32'(n_pops), 32'd0);
    chk("gate_empty", 32'(empty), 32'd0);
    event_ready = 1'b1;
    tick();
    chk("pop_once", 32'(n_pops), 32'd1);
    chk("pop_empty", 32'(empty), 32'd1);
    tick();
    chk("lat1_valid", 32'(event_valid), 32'd0);
    tick();
    chk("lat2_valid", 32'(event_valid), 32'd1);
    chk("ev_x", 32'(event_x), 32'd10);
    chk("ev_y", 32'(event_y), 32'd20);
    repeat (2) tick();
    chk("hold_valid", 32'(event_valid), 32'd1);
    chk("hold_xy", 32'({event_x, event_y}), 32'h0A14);
    event_ack = 1'b1;
    tick();
    event_ack = 1'b0;
    chk("ack_valid", 32'(event_valid), 32'd0);
    chk("ack_active", 32'(active), 32'd0);
    for (int pass = 0; pass < 2; pass++) begin
      event_ready = 1'b0;
      for (int k = 0; k < 9; k++) write_ev(16'((pass ? 16'h0300 : 16'h0100) + k));
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_count", 32'(fifo_count), 32'd8);
      event_ready = 1'b1;
      event_ack = 1'b1;
      for (int k = 0; k < 8; k++) begin
        wait_valid();
        chk("drain_x", 32'(event_x), pass ? 32'd3 : 32'd1);
        chk("drain_y", 32'(event_y), 32'(k));
        tick();
      end
      event_ack = 1'b0;
      tick();
      chk("drain_empty", 32'(empty), 32'd1);
    end
    write_ev(16'h0506);
    write_ev(16'h0708);
    wait_valid();
    chk("en_first", 32'({event_x, event_y}), 32'h0506);
    enable = 1'b0;
    tick();
    chk("en_hold", 32'(event_valid), 32'd1);
    event_ack = 1'b1;
    tick();
    event_ack = 1'b0;
    chk("en_done", 32'(event_valid), 32'd0);
    p0 = n_pops;
    repeat (5) tick();
    chk("en_nopop", 32'(n_pops), 32'(p0));
    chk("en_count", 32'(fifo_count), 32'd1);
    chk("en_active", 32'(active), 32'd0);
    enable = 1'b1;
    wait_valid();
    chk("en_second", 32'({event_x, event_y}), 32'h0708);
    event_ack = 1'b1;
    tick();
    event_ack = 1'b0;
`ifdef CAPTURE_BOUNDS_CHECK_EN
    p0 = n_drops;
    write_ev(16'h2805);
    write_ev(16'h0305);
    wait_valid();
    chk("bc_drops", 32'(n_drops - p0), 32'd1);
    chk("bc_xy", 32'({event_x, event_y}), 32'h0305);
    event_ack = 1'b1;
    tick();
    event_ack = 1'b0;
`endif
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      write_en = $urandom_range(0, 1) == 1;
      write_data = 16'($urandom);
      if ($urandom_range(0, 1) == 1) write_data[15:8] = 8'($urandom_range(0, 40));
      if ($urandom_range(0, 1) == 1) write_data[7:0] = 8'($urandom_range(0, 40));
      enable = $urandom_range(0, 99) < 85;
      event_ready = $urandom_range(0, 99) < 70;
      event_ack = $urandom_range(0, 99) < 40;
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
